prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side PRBS15 (x^15+x^14+1) pattern checker for the PRBS link test path.
//  - Consumes the byte stream produced by the PRBS generator, 8 bits per valid beat.
//  - Self-synchronises its LFSR from the received data and declares lock.
//  - Counts bit errors once locked; exposes lock status and error/byte counters to test logic.
// PARAMETERS
//  LOCK_BYTES  4   consecutive error-free bytes in HUNT needed to assert lock
//  LOSS_BYTES  4   consecutive bytes with >=1 bit error in LOCK that drop lock
//  ERR_W       16  width of err_cnt (saturating)
//  BYTE_W      32  width of byte_cnt (wrapping)
// PORTS
//  CLK       in   1       clock, all logic on posedge
//  RST       in   1       synchronous reset, active-high
//  en        in   1       checker enable; low forces IDLE
//  clr       in   1       clear err_cnt and byte_cnt (one-cycle pulse)
//  in_valid  in   1       in_data carries a byte this cycle
//  in_data   in   8       received byte; bit 7 is the earliest bit on the line
//  locked    out  1       pattern lock (high only in LOCK)
//  err_bits  out  4       bit errors in the last checked byte (0..8)
//  err_pulse out  1       one-cycle strobe: last byte checked in LOCK had err_bits!=0
//  err_cnt   out  ERR_W   accumulated bit errors while locked, saturates at all-ones
//  byte_cnt  out  BYTE_W  bytes checked while locked, wraps modulo 2^BYTE_W
// BEHAVIOUR
//  Reset (RST=1 on a CLK edge): state=IDLE, S[14:0]=0, all outputs 0, internal counters 0.
//  Per-bit step, bits b=in_data[7] down to in_data[0], within one cycle:
//   predicted p = S[14]^S[13]; error if b!=p; S <= {S[13:0], b} (received bit shifted in).
//   Result: one line bit error yields exactly 3 counted errors (at b, +14, +15 bits).
//  FSM (transitions only on in_valid=1 beats, except en):
//   IDLE: entered whenever en=0 (from any state, next cycle); S and counters hold; locked=0.
//         en=1 -> SYNC.
//   SYNC: shift received bits, no comparison; after 2 bytes (16 bits) -> HUNT,
//         unless S==0 after the 2nd byte -> stay SYNC, restart byte count (all-zero lockup).
//   HUNT: compare; clean byte -> clean_cnt+1, err byte -> clean_cnt=0;
//         clean_cnt reaching LOCK_BYTES -> LOCK. err_cnt/byte_cnt not updated.
//   LOCK: compare; err_cnt += err_bits (saturating), byte_cnt += 1;
//         err byte -> bad_cnt+1, clean byte -> bad_cnt=0; bad_cnt reaching LOSS_BYTES -> SYNC.
//         The byte causing loss of lock is still counted.
//  Latency: err_bits, err_pulse, counters, locked all registered; update the cycle after the beat.
//  err_bits updates on every checked beat (HUNT or LOCK), holds otherwise; err_pulse is 0 unless LOCK beat.
//  in_valid=0: no state change, S holds, err_pulse=0.
//  clr: err_cnt, byte_cnt <= 0; clr wins over a same-cycle LOCK beat (that beat's errors and
//   byte not counted, but S and FSM still advance). clr does not affect lock or S.
//  RST mid-operation: immediate return to reset values on that edge regardless of other inputs.
//  RST has priority over en, clr, in_valid.
// TESTING
//  1 Generator seed 15'h0011, en=1, 20 back-to-back beats -> locked rises cycle after 6th beat,
//    err_cnt=0, byte_cnt=14 after 20th beat.
//  2 Locked, flip bit 3 of one byte -> err_pulse on that and following byte(s), err_cnt=3 total,
//    locked stays 1.
//  3 Locked, replace 4 consecutive bytes with 8'hFF noise -> locked=0 after 4th, FSM re-syncs,
//    locked=1 again 6 clean beats later; err_cnt kept.
//  4 en=1, stream of 8'h00 -> stays SYNC, locked never 1; then valid PRBS -> locks in 6 beats.
//  5 clr with same-cycle erroneous LOCK beat -> err_cnt=0, byte_cnt=0 next cycle; ERR_W=4,
//    inject 6 single-bit errors (18 errors) -> err_cnt saturates at 15.
//  6 RST=1 while locked with in_valid=1 -> next cycle locked=0, counters 0, state IDLE; en low
//    mid-HUNT -> IDLE, counters hold.

Source files
------------

// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - control, byte stream and status bundle of the PRBS15 checker
interface prbs_checker_if #(
    parameter int ERR_W  = 16,
    parameter int BYTE_W = 32
);
    logic              en;
    logic              clr;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              locked;
    logic [3:0]        err_bits;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [BYTE_W-1:0] byte_cnt;

    modport master (
        output en, clr, in_valid, in_data,
        input  locked, err_bits, err_pulse, err_cnt, byte_cnt
    );

    modport slave (
        input  en, clr, in_valid, in_data,
        output locked, err_bits, err_pulse, err_cnt, byte_cnt
    );
endinterface

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS15 (x^15+x^14+1) byte-stream checker
module prbs_checker #(
    parameter int LOCK_BYTES = 4,
    parameter int LOSS_BYTES = 4,
    parameter int ERR_W      = 16,
    parameter int BYTE_W     = 32
) (
    input  logic           CLK,
    input  logic           RST,
    prbs_checker_if.slave  bus
);
    localparam int MAXB = (LOCK_BYTES > LOSS_BYTES) ? LOCK_BYTES : LOSS_BYTES;
    localparam int CW   = $clog2(MAXB + 1);

    typedef enum logic [1:0] {IDLE, SYNC, HUNT, LOCK} state_t;

    state_t            state_q, state_d;
    logic [14:0]       s_q, s_d;
    logic              sync_q, sync_d;
    logic [CW-1:0]     clean_q, clean_d;
    logic [CW-1:0]     bad_q, bad_d;
    logic [3:0]        err_bits_q, err_bits_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;

    logic [14:0]       s_walk;
    logic [3:0]        nerr;
    logic              lock_beat;
    logic [ERR_W:0]    err_sum;

    // Bit 7 is earliest on the line; the received bit (not the prediction) feeds the LFSR.
    always_comb begin
        s_walk = s_q;
        nerr   = '0;
        for (int i = 7; i >= 0; i--) begin
            nerr   = nerr + {3'b000, bus.in_data[i] ^ s_walk[14] ^ s_walk[13]};
            s_walk = {s_walk[13:0], bus.in_data[i]};
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        sync_d      = sync_q;
        clean_d     = clean_q;
        bad_d       = bad_q;
        err_bits_d  = err_bits_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        lock_beat   = 1'b0;
        err_sum     = {1'b0, err_cnt_q} + (ERR_W+1)'(nerr);

        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    sync_d  = 1'b0;
                end
                SYNC: if (bus.in_valid) begin
                    s_d    = s_walk;
                    sync_d = ~sync_q;
                    // An all-zero register would predict zeros forever, so keep syncing.
                    if (sync_q && (s_walk != '0)) begin
                        state_d = HUNT;
                        clean_d = '0;
                    end
                end
                HUNT: if (bus.in_valid) begin
                    s_d        = s_walk;
                    err_bits_d = nerr;
                    if (nerr != '0) begin
                        clean_d = '0;
                    end else if (clean_q == CW'(LOCK_BYTES - 1)) begin
                        state_d = LOCK;
                        clean_d = '0;
                        bad_d   = '0;
                    end else begin
                        clean_d = clean_q + 1'b1;
                    end
                end
                LOCK: if (bus.in_valid) begin
                    s_d         = s_walk;
                    err_bits_d  = nerr;
                    err_pulse_d = (nerr != '0);
                    lock_beat   = 1'b1;
                    if (nerr == '0) begin
                        bad_d = '0;
                    end else if (bad_q == CW'(LOSS_BYTES - 1)) begin
                        state_d = SYNC;
                        sync_d  = 1'b0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.clr) begin
            err_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (lock_beat) begin
            err_cnt_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            s_q         <= '0;
            sync_q      <= 1'b0;
            clean_q     <= '0;
            bad_q       <= '0;
            err_bits_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            sync_q      <= sync_d;
            clean_q     <= clean_d;
            bad_q       <= bad_d;
            err_bits_q  <= err_bits_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign bus.locked    = (state_q == LOCK);
    assign bus.err_bits  = err_bits_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.byte_cnt  = byte_cnt_q;
endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed bench for prbs_checker (default and 4-bit err_cnt instances)
module tb_prbs_checker;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [14:0] g_s;

    prbs_checker_if #(.ERR_W(16), .BYTE_W(32)) bus ();
    prbs_checker_if #(.ERR_W(4),  .BYTE_W(32)) bus4 ();

    assign bus.en        = en;
    assign bus.clr       = clr;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus4.en       = en;
    assign bus4.clr      = clr;
    assign bus4.in_valid = in_valid;
    assign bus4.in_data  = in_data;

    prbs_checker #(.LOCK_BYTES(4), .LOSS_BYTES(4), .ERR_W(16), .BYTE_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    prbs_checker #(.LOCK_BYTES(4), .LOSS_BYTES(4), .ERR_W(4), .BYTE_W(32)) dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4.slave)
    );

    always #5 CLK = ~CLK;

    // Reference PRBS15 generator: out = g[14]^g[13], shifted in LSB-first, MSB of byte first.
    task automatic gen_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            b[i] = g_s[14] ^ g_s[13];
            g_s  = {g_s[13:0], b[i]};
        end
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0d exp 0", bus.locked); end
        checks++; if (bus.err_bits !== 4'd0) begin errors++; $display("FAIL rst_err_bits got %0d exp 0", bus.err_bits); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got %0d exp 0", bus.err_pulse); end
        checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd0) begin errors++; $display("FAIL rst_byte_cnt got %0d exp 0", bus.byte_cnt); end
    endtask

    task automatic test_lock();
        logic [7:0] g;
        g_s = 15'h0011;
        en  = 1'b1;
        idle(1);
        for (int i = 1; i <= 20; i++) begin
            gen_byte(g);
            beat(g);
            if (i == 5) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0d exp 0", bus.locked); end
            end
            if (i == 6) begin
                checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_rise got %0d exp 1", bus.locked); end
            end
        end
        checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL lock_err_cnt got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd14) begin errors++; $display("FAIL lock_byte_cnt got %0d exp 14", bus.byte_cnt); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL lock_err_pulse got %0d exp 0", bus.err_pulse); end
    endtask

    // Flipping in_data[3] (bit offset 4 in the byte) also corrupts predictions at offsets 18 and 19.
    task automatic test_single_error();
        logic [7:0] g;
        gen_byte(g); beat(g ^ 8'h08);
        checks++; if (bus.err_bits !== 4'd1) begin errors++; $display("FAIL se_bits0 got %0d exp 1", bus.err_bits); end
        checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL se_pulse0 got %0d exp 1", bus.err_pulse); end
        gen_byte(g); beat(g);
        checks++; if (bus.err_bits !== 4'd0) begin errors++; $display("FAIL se_bits1 got %0d exp 0", bus.err_bits); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL se_pulse1 got %0d exp 0", bus.err_pulse); end
        gen_byte(g); beat(g);
        checks++; if (bus.err_bits !== 4'd2) begin errors++; $display("FAIL se_bits2 got %0d exp 2", bus.err_bits); end
        checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL se_pulse2 got %0d exp 1", bus.err_pulse); end
        gen_byte(g); beat(g);
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL se_pulse3 got %0d exp 0", bus.err_pulse); end
        checks++; if (bus.err_cnt !== 16'd3) begin errors++; $display("FAIL se_err_cnt got %0d exp 3", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd18) begin errors++; $display("FAIL se_byte_cnt got %0d exp 18", bus.byte_cnt); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL se_locked got %0d exp 1", bus.locked); end
    endtask

    task automatic test_loss_relock();
        logic [7:0] g;
        logic [7:0] first;
        int         exp_bytes;
        gen_byte(g); first = g; beat(8'hFF);
        gen_byte(g); beat(8'hFF);
        gen_byte(g); beat(8'hFF);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL loss_hold got %0d exp 1", bus.locked); end
        gen_byte(g); beat(8'hFF);
        // A noise byte that happens to equal the true data is clean, delaying loss by one byte.
        exp_bytes = (first == 8'hFF) ? 23 : 22;
        if (first == 8'hFF) begin
            gen_byte(g); beat(8'hFF);
        end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL loss_drop got %0d exp 0", bus.locked); end
        checks++; if (bus.byte_cnt !== 32'(exp_bytes)) begin errors++; $display("FAIL loss_byte_cnt got %0d exp %0d", bus.byte_cnt, exp_bytes); end
        checks++; if (bus.err_cnt < 16'd21 || bus.err_cnt > 16'd35) begin errors++; $display("FAIL loss_err_cnt got %0d exp 21..35", bus.err_cnt); end
        for (int i = 1; i <= 6; i++) begin
            gen_byte(g); beat(g);
            if (i == 5) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0d exp 0", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock got %0d exp 1", bus.locked); end
        checks++; if (bus.byte_cnt !== 32'(exp_bytes)) begin errors++; $display("FAIL relock_byte_cnt got %0d exp %0d", bus.byte_cnt, exp_bytes); end
        checks++; if (bus.err_cnt < 16'd21 || bus.err_cnt > 16'd35) begin errors++; $display("FAIL relock_err_cnt got %0d exp 21..35", bus.err_cnt); end
    endtask

    task automatic test_zero_lockup();
        logic [7:0] g;
        logic       seen;
        do_reset();
        en = 1'b1;
        idle(1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(8'h00);
            seen = seen | bus.locked;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_locked got %0d exp 0", seen); end
        checks++; if (bus.err_bits !== 4'd0) begin errors++; $display("FAIL zero_err_bits got %0d exp 0", bus.err_bits); end
        g_s = 15'h0011;
        for (int i = 1; i <= 6; i++) begin
            gen_byte(g); beat(g);
            if (i == 5) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL zero_lock_early got %0d exp 0", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL zero_lock got %0d exp 1", bus.locked); end
        checks++; if (bus.byte_cnt !== 32'd0) begin errors++; $display("FAIL zero_byte_cnt got %0d exp 0", bus.byte_cnt); end
    endtask

    task automatic test_clr_saturate();
        logic [7:0] g;
        gen_byte(g); beat(g);
        gen_byte(g); beat(g);
        checks++; if (bus.byte_cnt !== 32'd2) begin errors++; $display("FAIL clr_pre_bytes got %0d exp 2", bus.byte_cnt); end
        clr = 1'b1;
        gen_byte(g); beat(g ^ 8'h08);
        clr = 1'b0;
        checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL clr_err_cnt got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd0) begin errors++; $display("FAIL clr_byte_cnt got %0d exp 0", bus.byte_cnt); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %0d exp 1", bus.locked); end
        gen_byte(g); beat(g);
        gen_byte(g); beat(g);
        checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL clr_tail_err got %0d exp 2", bus.err_cnt); end
        checks++; if (bus4.err_cnt !== 4'd2) begin errors++; $display("FAIL sat_tail_err got %0d exp 2", bus4.err_cnt); end
        for (int k = 1; k <= 6; k++) begin
            gen_byte(g); beat(g ^ 8'h08);
            gen_byte(g); beat(g);
            gen_byte(g); beat(g);
            if (k == 1) begin
                checks++; if (bus4.err_cnt !== 4'd5) begin errors++; $display("FAIL sat_first got %0d exp 5", bus4.err_cnt); end
            end
        end
        checks++; if (bus.err_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", bus.err_cnt); end
        checks++; if (bus4.err_cnt !== 4'd15) begin errors++; $display("FAIL sat_narrow got %0d exp 15", bus4.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd20) begin errors++; $display("FAIL sat_byte_cnt got %0d exp 20", bus.byte_cnt); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %0d exp 1", bus.locked); end
    endtask

    task automatic test_en_rst();
        logic [7:0] g;
        en = 1'b0;
        idle(1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL en_off_locked got %0d exp 0", bus.locked); end
        beat(8'hA5);
        checks++; if (bus.byte_cnt !== 32'd20) begin errors++; $display("FAIL en_off_bytes got %0d exp 20", bus.byte_cnt); end
        checks++; if (bus.err_bits !== 4'd2) begin errors++; $display("FAIL en_off_bits got %0d exp 2", bus.err_bits); end
        en = 1'b1;
        idle(1);
        g_s = 15'h0011;
        for (int i = 0; i < 3; i++) begin
            gen_byte(g); beat(g);
        end
        en = 1'b0;
        idle(1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL hunt_off_locked got %0d exp 0", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd20) begin errors++; $display("FAIL hunt_off_err got %0d exp 20", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd20) begin errors++; $display("FAIL hunt_off_bytes got %0d exp 20", bus.byte_cnt); end
        en = 1'b1;
        idle(1);
        for (int i = 0; i < 6; i++) begin
            gen_byte(g); beat(g);
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL reen_lock got %0d exp 1", bus.locked); end
        gen_byte(g);
        in_valid = 1'b1;
        in_data  = g ^ 8'h08;
        RST      = 1'b1;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        in_valid = 1'b0;
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mrst_locked got %0d exp 0", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL mrst_err_cnt got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.byte_cnt !== 32'd0) begin errors++; $display("FAIL mrst_byte_cnt got %0d exp 0", bus.byte_cnt); end
        checks++; if (bus.err_bits !== 4'd0) begin errors++; $display("FAIL mrst_err_bits got %0d exp 0", bus.err_bits); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL mrst_err_pulse got %0d exp 0", bus.err_pulse); end
        idle(1);
        for (int i = 1; i <= 6; i++) begin
            gen_byte(g); beat(g);
            if (i == 5) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mrst_relock_early got %0d exp 0", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL mrst_relock got %0d exp 1", bus.locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zero_lockup();
        test_clr_saturate();
        test_en_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
